i2c_eeprom_arbiter: RTL and testbench
=====================================

# i2c_eeprom_arbiter

Two-port round-robin arbiter and sequencer in front of `i2c_eeprom_top`. It accepts byte-write and random-read commands from two independent requesters. It serialises them onto the single I2C master request/ack interface and returns completion, read data and a timeout error to the owning requester. After every write it enforces the EEPROM internal write-cycle gap before issuing the next transaction.

## Interface
- `TIMEOUT_CYCLES`, 200000: max cycles from request assertion to ack before abort; must be >= 2.
- `WR_GAP_CYCLES`, 250000: idle cycles inserted after a write or a timeout (5 ms at 50 MHz); must be >= 1.

- `clk`  input  1  single clock for all logic.
- `reset_n`  input  1  asynchronous, active-low reset.
- `req0_valid` / `req1_valid`  input  1  command pending; held with fields stable until `reqN_ready`.
- `req0_rw` / `req1_rw`  input  1  1 = random read, 0 = byte write.
- `req0_dev_addr` / `req1_dev_addr`  input  8  device address.
- `req0_reg_addr` / `req1_reg_addr`  input  8  register address.
- `req0_wdata` / `req1_wdata`  input  8  write data; ignored for reads.
- `req0_ready` / `req1_ready`  output  1  one-cycle pulse: command accepted.
- `req0_done` / `req1_done`  output  1  one-cycle pulse: command finished.
- `req0_err` / `req1_err`  output  1  valid with `done`: 1 = timed out.
- `req_rdata`  output  8  read data; valid with a `done` pulse of a read with `err`=0.
- `busy`  output  1  high in any state other than IDLE.
- `i2c_write_req` / `i2c_read_req`  output  1  level request to the master.
- `i2c_write_ack` / `i2c_read_ack`  input  1  completion pulse from the master.
- `wr_dev_addr`, `wr_reg_addr`, `wdata_in`, `rd_dev_addr`, `rd_reg_addr`  output  8  latched command fields, driven to the master.
- `rdata`  input  8  master read data; valid in the cycle `i2c_read_ack` is high.

## Operation
- States: IDLE, BUSY, GAP.
- IDLE:
  - If exactly one `reqN_valid` is high, grant it.
  - If both are high, grant the requester not granted last. The `last_grant` reset value is 1, so port 0 wins the first tie.
  - On grant: latch rw/addresses/wdata, update `last_grant`, clear the timeout counter, go to BUSY.
- BUSY:
  - `i2c_write_req` or `i2c_read_req` (per latched rw) is high for the whole state.
  - The counter increments each cycle.
  - A matching ack ends the transaction: drop the request, pulse `done` with `err`=0, and capture `rdata` into `req_rdata` on a read. Next state is GAP after a write, IDLE after a read.
  - The non-matching ack is ignored.
  - If the counter reaches TIMEOUT_CYCLES-1 with no matching ack: drop the request, pulse `done` with `err`=1, go to GAP. `req_rdata` is unchanged.
  - Ack and timeout in the same cycle: ack wins.
- GAP: count WR_GAP_CYCLES cycles with all requests low, then go to IDLE. `reqN_valid` is ignored during GAP.
- `wr_*`, `rd_*` and `wdata_in` outputs always reflect the latched command, with both address sets driven identically. They hold their value after completion.
- Reset values: all outputs 0, state IDLE, counters 0, `last_grant`=1.
- Reset asserted mid-transaction drops the I2C request immediately and produces no `done` pulse.

## Timing
- Grant:
  - `reqN_valid` sampled high in IDLE at edge T.
  - In cycle T+1: `reqN_ready`=1 (exactly one cycle), `i2c_*_req`=1, `busy`=1.
- A requester must deassert `valid` no later than the cycle after `ready`, or it is taken as a new command at the next IDLE.
- Completion:
  - Matching ack sampled at edge A.
  - In cycle A+1: `i2c_*_req`=0, `reqN_done`=1, `req_rdata` valid. State is IDLE (read) or the first GAP cycle (write).
- Minimum request-to-request spacing:
  - Read: the next grant can be sampled at edge A+1, giving a request at A+2.
  - Write: WR_GAP_CYCLES further cycles are added.
- Timeout: the request is high for exactly TIMEOUT_CYCLES cycles, then `done`/`err` pulse in the next cycle.
- Counter widths: `$clog2` of (parameter + 1). No wrap-around is possible.

## Test plan
Parameters: TIMEOUT_CYCLES=64, WR_GAP_CYCLES=16.

- Single write: req0 write dev 0xA0, reg 0x12, data 0x5A; master model acks after 10 cycles.
  - `req0_ready` pulse; `i2c_write_req` high 10 cycles; `wr_reg_addr`=0x12, `wdata_in`=0x5A.
  - `req0_done`=1, `err`=0; `busy` then stays high 16 more cycles.
- Single read: req1 read dev 0xA1, reg 0x34; master acks with `rdata`=0xC3.
  - `req1_done`=1, `req_rdata`=0xC3 in the cycle after ack; no GAP.
- Contention: both valid from reset, each with 3 back-to-back reads.
  - Grants alternate 0,1,0,1,0,1.
  - `last_grant` is respected after a single-requester period.
- Timeout: req0 write, master never acks.
  - `i2c_write_req` high exactly 64 cycles; `req0_done`=`req0_err`=1; 16-cycle GAP follows.
- Edge acks:
  - `i2c_read_ack` during a write is ignored.
  - Matching ack on counter value 63 gives `err`=0.
- Reset mid-BUSY drives all outputs to 0 with no `done`; the next command after reset completes normally.

Source files
------------

// File: rtl/i2c_eeprom_arbiter.sv
// Round-robin arbiter/sequencer: two requesters share one I2C EEPROM master.
// Grant visible one cycle after valid is sampled; writes and timeouts are followed by a write-cycle gap.
module i2c_eeprom_arbiter #(
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int WR_GAP_CYCLES  = 250000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0_valid,
  input  logic       req0_rw,
  input  logic [7:0] req0_dev_addr,
  input  logic [7:0] req0_reg_addr,
  input  logic [7:0] req0_wdata,
  input  logic       req1_valid,
  input  logic       req1_rw,
  input  logic [7:0] req1_dev_addr,
  input  logic [7:0] req1_reg_addr,
  input  logic [7:0] req1_wdata,
  output logic       req0_ready,
  output logic       req1_ready,
  output logic       req0_done,
  output logic       req1_done,
  output logic       req0_err,
  output logic       req1_err,
  output logic [7:0] req_rdata,
  output logic       busy,
  output logic       i2c_write_req,
  output logic       i2c_read_req,
  input  logic       i2c_write_ack,
  input  logic       i2c_read_ack,
  output logic [7:0] wr_dev_addr,
  output logic [7:0] wr_reg_addr,
  output logic [7:0] wdata_in,
  output logic [7:0] rd_dev_addr,
  output logic [7:0] rd_reg_addr,
  input  logic [7:0] rdata
);

  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(WR_GAP_CYCLES + 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(WR_GAP_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]       state;
  logic [TO_W-1:0]  to_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             last_grant;
  logic             cmd_rw;
  logic [7:0]       cmd_dev;
  logic [7:0]       cmd_reg;
  logic [7:0]       cmd_wdata;
  logic             ready_q;
  logic             done_q;
  logic             err_q;
  logic [7:0]       rdata_q;

  logic grant_any;
  logic grant_sel;
  logic ack_hit;

  // On a tie the port not granted last wins; otherwise whichever one is asking.
  assign grant_any = req0_valid | req1_valid;
  assign grant_sel = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
  assign ack_hit   = cmd_rw ? i2c_read_ack : i2c_write_ack;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      to_cnt     <= '0;
      gap_cnt    <= '0;
      last_grant <= 1'b1;
      cmd_rw     <= 1'b0;
      cmd_dev    <= '0;
      cmd_reg    <= '0;
      cmd_wdata  <= '0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            last_grant <= grant_sel;
            ready_q    <= 1'b1;
            to_cnt     <= '0;
            state      <= ST_BUSY;
            cmd_rw     <= grant_sel ? req1_rw       : req0_rw;
            cmd_dev    <= grant_sel ? req1_dev_addr : req0_dev_addr;
            cmd_reg    <= grant_sel ? req1_reg_addr : req0_reg_addr;
            cmd_wdata  <= grant_sel ? req1_wdata    : req0_wdata;
          end
        end
        ST_BUSY: begin
          // A matching ack takes priority over a timeout in the same cycle.
          if (ack_hit) begin
            done_q <= 1'b1;
            if (cmd_rw) begin
              rdata_q <= rdata;
              state   <= ST_IDLE;
            end else begin
              gap_cnt <= '0;
              state   <= ST_GAP;
            end
          end else if (to_cnt == TO_LAST) begin
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            gap_cnt <= '0;
            state   <= ST_GAP;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // last_grant stays on the owner for the whole transaction, so it routes the pulses.
  assign req0_ready    = ready_q & ~last_grant;
  assign req1_ready    = ready_q &  last_grant;
  assign req0_done     = done_q  & ~last_grant;
  assign req1_done     = done_q  &  last_grant;
  assign req0_err      = err_q   & ~last_grant;
  assign req1_err      = err_q   &  last_grant;
  assign req_rdata     = rdata_q;
  assign busy          = (state != ST_IDLE);
  assign i2c_write_req = (state == ST_BUSY) & ~cmd_rw;
  assign i2c_read_req  = (state == ST_BUSY) &  cmd_rw;
  assign wr_dev_addr   = cmd_dev;
  assign rd_dev_addr   = cmd_dev;
  assign wr_reg_addr   = cmd_reg;
  assign rd_reg_addr   = cmd_reg;
  assign wdata_in      = cmd_wdata;

endmodule

// File: tb/tb_i2c_eeprom_arbiter.sv
// Directed testbench for i2c_eeprom_arbiter with TIMEOUT_CYCLES=64, WR_GAP_CYCLES=16.
module tb_i2c_eeprom_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req0_valid, req0_rw, req1_valid, req1_rw;
  logic [7:0] req0_dev_addr, req0_reg_addr, req0_wdata;
  logic [7:0] req1_dev_addr, req1_reg_addr, req1_wdata;
  logic       req0_ready, req1_ready, req0_done, req1_done, req0_err, req1_err;
  logic [7:0] req_rdata;
  logic       busy, i2c_write_req, i2c_read_req;
  logic       i2c_write_ack, i2c_read_ack;
  logic [7:0] wr_dev_addr, wr_reg_addr, wdata_in, rd_dev_addr, rd_reg_addr;
  logic [7:0] rdata;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] last_rd;

  i2c_eeprom_arbiter #(.TIMEOUT_CYCLES(64), .WR_GAP_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_dev_addr(req0_dev_addr),
    .req0_reg_addr(req0_reg_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_dev_addr(req1_dev_addr),
    .req1_reg_addr(req1_reg_addr), .req1_wdata(req1_wdata),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_done(req0_done), .req1_done(req1_done),
    .req0_err(req0_err), .req1_err(req1_err),
    .req_rdata(req_rdata), .busy(busy),
    .i2c_write_req(i2c_write_req), .i2c_read_req(i2c_read_req),
    .i2c_write_ack(i2c_write_ack), .i2c_read_ack(i2c_read_ack),
    .wr_dev_addr(wr_dev_addr), .wr_reg_addr(wr_reg_addr), .wdata_in(wdata_in),
    .rd_dev_addr(rd_dev_addr), .rd_reg_addr(rd_reg_addr), .rdata(rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req0_valid = 0; req0_rw = 0; req0_dev_addr = 0; req0_reg_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_rw = 0; req1_dev_addr = 0; req1_reg_addr = 0; req1_wdata = 0;
    i2c_write_ack = 0; i2c_read_ack = 0; rdata = 0;
    tick(); tick();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_chk++; if ({i2c_write_req, i2c_read_req} !== 2'b00) begin n_fail++; $display("FAIL rst_req: got %b want 00", {i2c_write_req, i2c_read_req}); end
    n_chk++; if ({req0_ready, req1_ready, req0_done, req1_done, req0_err, req1_err} !== 6'b0) begin
      n_fail++; $display("FAIL rst_pulses: got %b want 000000", {req0_ready, req1_ready, req0_done, req1_done, req0_err, req1_err}); end
    n_chk++; if ({req_rdata, wr_dev_addr, wr_reg_addr, wdata_in, rd_dev_addr, rd_reg_addr} !== 48'h0) begin
      n_fail++; $display("FAIL rst_data: got %h want 0", {req_rdata, wr_dev_addr, wr_reg_addr, wdata_in, rd_dev_addr, rd_reg_addr}); end
    reset_n = 1'b1;
    tick();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_write();
    int hi, cnt;
    req0_valid = 1; req0_rw = 0; req0_dev_addr = 8'hA0; req0_reg_addr = 8'h12; req0_wdata = 8'h5A;
    tick();
    n_chk++; if ({req0_ready, req1_ready, i2c_write_req, i2c_read_req, busy} !== 5'b10101) begin
      n_fail++; $display("FAIL wr_grant: got %b want 10101", {req0_ready, req1_ready, i2c_write_req, i2c_read_req, busy}); end
    n_chk++; if ({wr_dev_addr, wr_reg_addr, wdata_in, rd_dev_addr, rd_reg_addr} !== 40'hA0_12_5A_A0_12) begin
      n_fail++; $display("FAIL wr_fields: got %h want a0125aa012", {wr_dev_addr, wr_reg_addr, wdata_in, rd_dev_addr, rd_reg_addr}); end
    req0_valid = 0;
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (i2c_write_req) hi++;
      i2c_write_ack = (i == 9);
      tick();
      if (i == 0) begin
        n_chk++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL wr_ready_pulse: got %b want 0", req0_ready); end
      end
    end
    i2c_write_ack = 0;
    n_chk++; if (hi != 10) begin n_fail++; $display("FAIL wr_req_len: got %0d want 10", hi); end
    n_chk++; if ({req0_done, req0_err, req1_done, i2c_write_req} !== 4'b1000) begin
      n_fail++; $display("FAIL wr_done: got %b want 1000", {req0_done, req0_err, req1_done, i2c_write_req}); end
    cnt = 0;
    while (busy && cnt < 100) begin cnt++; tick(); end
    n_chk++; if (cnt != 16) begin n_fail++; $display("FAIL wr_gap: got %0d want 16", cnt); end
  endtask

  task automatic test_single_read();
    req1_valid = 1; req1_rw = 1; req1_dev_addr = 8'hA1; req1_reg_addr = 8'h34; req1_wdata = 8'hFF;
    tick();
    n_chk++; if ({req1_ready, req0_ready, i2c_read_req, i2c_write_req} !== 4'b1010) begin
      n_fail++; $display("FAIL rd_grant: got %b want 1010", {req1_ready, req0_ready, i2c_read_req, i2c_write_req}); end
    n_chk++; if ({rd_dev_addr, rd_reg_addr, wr_reg_addr} !== 24'hA1_34_34) begin
      n_fail++; $display("FAIL rd_fields: got %h want a13434", {rd_dev_addr, rd_reg_addr, wr_reg_addr}); end
    req1_valid = 0;
    tick(); tick();
    i2c_read_ack = 1; rdata = 8'hC3;
    tick();
    i2c_read_ack = 0; rdata = 8'h00;
    n_chk++; if ({req1_done, req1_err, req0_done, i2c_read_req, busy} !== 5'b10000) begin
      n_fail++; $display("FAIL rd_done: got %b want 10000", {req1_done, req1_err, req0_done, i2c_read_req, busy}); end
    n_chk++; if (req_rdata !== 8'hC3) begin n_fail++; $display("FAIL rd_data: got %h want c3", req_rdata); end
    tick();
    n_chk++; if ({req1_done, req_rdata} !== 9'h0C3) begin n_fail++; $display("FAIL rd_hold: got %h want 0c3", {req1_done, req_rdata}); end
  endtask

  task automatic test_back_to_back();
    int exp_g[6] = '{0, 1, 0, 1, 0, 1};
    int n0, n1, w, port;
    logic [7:0] exp_reg;
    reset_n = 0;
    tick();
    n0 = 0; n1 = 0;
    req0_valid = 1; req0_rw = 1; req0_dev_addr = 8'hA0; req0_reg_addr = 8'h00;
    req1_valid = 1; req1_rw = 1; req1_dev_addr = 8'hA1; req1_reg_addr = 8'h10;
    tick();
    reset_n = 1;
    for (int g = 0; g < 6; g++) begin
      w = 0;
      do begin tick(); w++; end while (!(req0_ready || req1_ready) && w < 50);
      port = req1_ready ? 1 : 0;
      exp_reg = port ? (8'h10 + 8'(n1)) : (8'h00 + 8'(n0));
      n_chk++; if (w >= 50 || port != exp_g[g]) begin n_fail++; $display("FAIL rr_grant%0d: got port %0d (wait %0d) want %0d", g, port, w, exp_g[g]); end
      n_chk++; if (rd_reg_addr !== exp_reg) begin n_fail++; $display("FAIL rr_reg%0d: got %h want %h", g, rd_reg_addr, exp_reg); end
      if (port == 0) begin n0++; if (n0 == 3) req0_valid = 0; else req0_reg_addr = 8'h00 + 8'(n0); end
      else begin n1++; if (n1 == 3) req1_valid = 0; else req1_reg_addr = 8'h10 + 8'(n1); end
      tick(); tick();
      i2c_read_ack = 1; rdata = ~exp_reg;
      tick();
      i2c_read_ack = 0; rdata = 0;
      n_chk++; if ({req1_done, req0_done} !== (port ? 2'b10 : 2'b01) || req_rdata !== ~exp_reg) begin
        n_fail++; $display("FAIL rr_done%0d: got %b/%h want port %0d/%h", g, {req1_done, req0_done}, req_rdata, port, ~exp_reg); end
    end
    // single request from port 0, then a tie must go to port 1
    req0_valid = 1; req0_reg_addr = 8'h20;
    tick();
    n_chk++; if ({req1_ready, req0_ready} !== 2'b01) begin n_fail++; $display("FAIL solo_grant: got %b want 01", {req1_ready, req0_ready}); end
    req0_valid = 0;
    tick(); tick();
    i2c_read_ack = 1; rdata = 8'h21;
    tick();
    i2c_read_ack = 0;
    req0_valid = 1; req0_reg_addr = 8'h30; req1_valid = 1; req1_reg_addr = 8'h31;
    tick();
    n_chk++; if ({req1_ready, req0_ready, rd_reg_addr} !== {2'b10, 8'h31}) begin
      n_fail++; $display("FAIL tie_after_solo: got %b/%h want 10/31", {req1_ready, req0_ready}, rd_reg_addr); end
    req0_valid = 0; req1_valid = 0;
    tick(); tick();
    i2c_read_ack = 1; rdata = 8'h5C;
    tick();
    i2c_read_ack = 0; rdata = 0;
    last_rd = 8'h5C;
    n_chk++; if ({req1_done, req_rdata} !== 9'h15C) begin n_fail++; $display("FAIL tie_done: got %h want 15c", {req1_done, req_rdata}); end
  endtask

  task automatic test_timeout();
    int hi, cnt, w;
    logic rdy_seen;
    req0_valid = 1; req0_rw = 0; req0_dev_addr = 8'hA0; req0_reg_addr = 8'h40; req0_wdata = 8'h11;
    tick();
    n_chk++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL to_grant: got %b want 1", req0_ready); end
    req0_valid = 0;
    hi = 0; w = 0;
    while (i2c_write_req && w < 200) begin hi++; w++; tick(); end
    n_chk++; if (hi != 64) begin n_fail++; $display("FAIL to_req_len: got %0d want 64", hi); end
    n_chk++; if ({req0_done, req0_err, req1_done} !== 3'b110) begin n_fail++; $display("FAIL to_err: got %b want 110", {req0_done, req0_err, req1_done}); end
    n_chk++; if (req_rdata !== last_rd) begin n_fail++; $display("FAIL to_rdata: got %h want %h", req_rdata, last_rd); end
    // port 1 waits through the gap and must not be granted early
    req1_valid = 1; req1_rw = 1; req1_reg_addr = 8'h50;
    cnt = 0; rdy_seen = 0;
    while (busy && cnt < 100) begin if (req1_ready) rdy_seen = 1; cnt++; tick(); end
    n_chk++; if (cnt != 16 || rdy_seen !== 1'b0) begin n_fail++; $display("FAIL to_gap: got %0d/%b want 16/0", cnt, rdy_seen); end
    tick();
    n_chk++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL post_gap_grant: got %b want 1", req1_ready); end
    req1_valid = 0;
    tick(); tick();
    i2c_read_ack = 1; rdata = 8'h77;
    tick();
    i2c_read_ack = 0; rdata = 0;
    n_chk++; if ({req1_done, req1_err, req_rdata} !== {2'b10, 8'h77}) begin
      n_fail++; $display("FAIL post_gap_done: got %b/%h want 10/77", {req1_done, req1_err}, req_rdata); end
  endtask

  task automatic test_edge_acks();
    int hi, cnt;
    req0_valid = 1; req0_rw = 0; req0_reg_addr = 8'h60; req0_wdata = 8'h22;
    tick();
    req0_valid = 0;
    hi = 0;
    for (int i = 0; i < 64; i++) begin
      if (i2c_write_req) hi++;
      i2c_read_ack  = (i == 5);
      i2c_write_ack = (i == 63);
      tick();
    end
    i2c_read_ack = 0; i2c_write_ack = 0;
    n_chk++; if (hi != 64) begin n_fail++; $display("FAIL edge_req_len: got %0d want 64", hi); end
    n_chk++; if ({req0_done, req0_err} !== 2'b10) begin n_fail++; $display("FAIL edge_last_ack: got %b want 10", {req0_done, req0_err}); end
    cnt = 0;
    while (busy && cnt < 100) begin cnt++; tick(); end
    n_chk++; if (cnt != 16) begin n_fail++; $display("FAIL edge_gap: got %0d want 16", cnt); end
  endtask

  task automatic test_reset_mid_busy();
    logic done_seen;
    req1_valid = 1; req1_rw = 0; req1_dev_addr = 8'hA2; req1_reg_addr = 8'h70; req1_wdata = 8'h33;
    tick();
    n_chk++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL mid_grant: got %b want 1", req1_ready); end
    req1_valid = 0;
    tick(); tick();
    reset_n = 0;
    #1;
    n_chk++; if ({i2c_write_req, i2c_read_req, busy, req0_done, req1_done} !== 5'b0) begin
      n_fail++; $display("FAIL mid_rst_ctl: got %b want 00000", {i2c_write_req, i2c_read_req, busy, req0_done, req1_done}); end
    n_chk++; if ({wr_dev_addr, wr_reg_addr, wdata_in, req_rdata} !== 32'h0) begin
      n_fail++; $display("FAIL mid_rst_data: got %h want 0", {wr_dev_addr, wr_reg_addr, wdata_in, req_rdata}); end
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (req0_done || req1_done) done_seen = 1; end
    reset_n = 1;
    tick();
    if (req0_done || req1_done) done_seen = 1;
    n_chk++; if (done_seen !== 1'b0) begin n_fail++; $display("FAIL mid_rst_nodone: got %b want 0", done_seen); end
    req0_valid = 1; req0_rw = 1; req0_dev_addr = 8'hA0; req0_reg_addr = 8'h7E;
    tick();
    n_chk++; if ({req0_ready, i2c_read_req, rd_reg_addr} !== {2'b11, 8'h7E}) begin
      n_fail++; $display("FAIL after_rst_grant: got %b/%h want 11/7e", {req0_ready, i2c_read_req}, rd_reg_addr); end
    req0_valid = 0;
    tick();
    i2c_read_ack = 1; rdata = 8'h99;
    tick();
    i2c_read_ack = 0; rdata = 0;
    n_chk++; if ({req0_done, req0_err, req_rdata} !== {2'b10, 8'h99}) begin
      n_fail++; $display("FAIL after_rst_done: got %b/%h want 10/99", {req0_done, req0_err}, req_rdata); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_back_to_back();
    test_timeout();
    test_edge_acks();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
